// File: rtl/conv_pkg.sv
// Shared types and helpers for the multi-channel convolution accumulator.
//   state_t  : controller states (S_IDLE, S_RUN, S_DRAIN, S_DONE)
//   out_dim  : output extent of a valid (no padding) strided window sweep
//   sat_s    : clip a signed value into the signed range of an ow-bit word
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic int out_dim(input int in_sz, input int k_sz, input int stride);
        return (in_sz - k_sz) / stride + 1;
    endfunction

    // Operates on 64-bit values, so callers must keep their accumulator at or
    // below 64 bits and sign-extend into the argument.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/conv_unit.sv
// Combinational K_H x K_W window dot product.
//   win : window pixels, two's complement, DATA_W each
//   wgt : kernel weights, two's complement, W_W each
//   sum : signed sum of products, every term sign-extended to ACC_W first
module conv_unit #(
    parameter int K_H    = 3,
    parameter int K_W    = 3,
    parameter int DATA_W = 24,
    parameter int W_W    = 8,
    parameter int ACC_W  = 40
) (
    input  logic        [K_H-1:0][K_W-1:0][DATA_W-1:0] win,
    input  logic        [K_H-1:0][K_W-1:0][W_W-1:0]    wgt,
    output logic signed [ACC_W-1:0]                    sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < K_H; i++) begin
            for (int j = 0; j < K_W; j++) begin
                sum = sum + ACC_W'($signed(win[i][j])) * ACC_W'($signed(wgt[i][j]));
            end
        end
    end

endmodule

// File: rtl/conv_mc_acc.sv
// Multi-channel convolution accumulator: one output channel, IN_CH input maps.
// Walks output pixels in raster order with the channel innermost, issuing one
// (pixel, channel) window per cycle into conv_unit; the result is accumulated
// the following cycle and the saturated sum lands in out_buff on the last
// channel of each pixel.
//   clk, rst_n : clock, asynchronous active-low reset
//   trigger    : start request, only sampled in S_IDLE
//   in_img     : [IN_CH][IN_H][IN_W] signed pixels, stable while busy
//   w_conv     : [IN_CH][K_H][K_W] signed weights, stable while busy
//   bias       : added once per output pixel
//   cal_chan   : channel tag, captured at trigger
//   busy       : high outside S_IDLE
//   out_buff   : [OUT_H][OUT_W] signed result map (not reset)
//   out_valid  : one-cycle pulse in S_DONE
//   out_chan   : tag of the run that produced out_buff
// Build option: define CONV_MC_RELU_EN to clamp negative saturated sums to 0.
// ACC_W must not exceed 64 (saturation is evaluated in 64 bits).
module conv_mc_acc
    import conv_pkg::*;
#(
    parameter int K_H    = 3,
    parameter int K_W    = 3,
    parameter int IN_H   = 14,
    parameter int IN_W   = 13,
    parameter int STRIDE = 1,
    parameter int IN_CH  = 4,
    parameter int DATA_W = 24,
    parameter int W_W    = 8,
    parameter int ACC_W  = 40,
    parameter int OUT_DW = 24,
    localparam int OUT_H = out_dim(IN_H, K_H, STRIDE),
    localparam int OUT_W = out_dim(IN_W, K_W, STRIDE)
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            trigger,
    input  logic        [IN_CH-1:0][IN_H-1:0][IN_W-1:0][DATA_W-1:0] in_img,
    input  logic        [IN_CH-1:0][K_H-1:0][K_W-1:0][W_W-1:0]      w_conv,
    input  logic signed [ACC_W-1:0]                         bias,
    input  logic        [3:0]                               cal_chan,
    output logic                                            busy,
    output logic        [OUT_H-1:0][OUT_W-1:0][OUT_DW-1:0]  out_buff,
    output logic                                            out_valid,
    output logic        [3:0]                               out_chan
);

    localparam int CW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int QW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int HW = (IN_H  > 1) ? $clog2(IN_H)  : 1;
    localparam int XW = (IN_W  > 1) ? $clog2(IN_W)  : 1;

    localparam logic [CW-1:0] C_LAST = CW'(IN_CH - 1);
    localparam logic [RW-1:0] R_LAST = RW'(OUT_H - 1);
    localparam logic [QW-1:0] Q_LAST = QW'(OUT_W - 1);

    state_t state, state_nxt;

    // issue-side counters (what is being fetched this cycle)
    logic [CW-1:0] c_cnt;
    logic [RW-1:0] r_cnt;
    logic [QW-1:0] q_cnt;
    logic          last_issue;

    // accumulate-side tags (what conv_unit is computing this cycle)
    logic          issue_vld;
    logic [CW-1:0] issue_c;
    logic [RW-1:0] issue_r;
    logic [QW-1:0] issue_q;

    logic [K_H-1:0][K_W-1:0][DATA_W-1:0] win_q;
    logic [K_H-1:0][K_W-1:0][W_W-1:0]    wgt_q;
    logic [K_H-1:0][HW-1:0]              row_idx;
    logic [K_W-1:0][XW-1:0]              col_idx;

    logic signed [ACC_W-1:0] conv_sum;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic        [OUT_DW-1:0] px_val;

    assign last_issue = (c_cnt == C_LAST) && (r_cnt == R_LAST) && (q_cnt == Q_LAST);

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        busy      = 1'b1;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                busy      = 1'b0;
                state_nxt = trigger ? S_RUN : S_IDLE;
            end
            S_RUN:   state_nxt = last_issue ? S_DRAIN : S_RUN;
            S_DRAIN: state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- issue counters ----------------
    // Channel innermost, then column, then row; all wrap to 0 on the last
    // issue so the next run starts from the origin without extra clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_cnt    <= '0;
            r_cnt    <= '0;
            q_cnt    <= '0;
            out_chan <= '0;
        end else begin
            if (state == S_IDLE && trigger) out_chan <= cal_chan;
            if (state == S_RUN) begin
                if (c_cnt == C_LAST) begin
                    c_cnt <= '0;
                    if (q_cnt == Q_LAST) begin
                        q_cnt <= '0;
                        r_cnt <= (r_cnt == R_LAST) ? '0 : r_cnt + RW'(1);
                    end else begin
                        q_cnt <= q_cnt + QW'(1);
                    end
                end else begin
                    c_cnt <= c_cnt + CW'(1);
                end
            end
        end
    end

    // ---------------- window fetch ----------------
    for (genvar i = 0; i < K_H; i++) begin : g_row
        assign row_idx[i] = HW'(int'(r_cnt) * STRIDE + i);
    end
    for (genvar j = 0; j < K_W; j++) begin : g_col
        assign col_idx[j] = XW'(int'(q_cnt) * STRIDE + j);
    end

    always_ff @(posedge clk) begin
        if (state == S_RUN) begin
            for (int i = 0; i < K_H; i++) begin
                for (int j = 0; j < K_W; j++) begin
                    win_q[i][j] <= in_img[c_cnt][row_idx[i]][col_idx[j]];
                    wgt_q[i][j] <= w_conv[c_cnt][i][j];
                end
            end
        end
    end

    conv_unit #(
        .K_H   (K_H),
        .K_W   (K_W),
        .DATA_W(DATA_W),
        .W_W   (W_W),
        .ACC_W (ACC_W)
    ) u_conv (
        .win(win_q),
        .wgt(wgt_q),
        .sum(conv_sum)
    );

    // ---------------- accumulate / write-back ----------------
    assign acc_nxt = (issue_c == '0) ? bias + conv_sum : acc + conv_sum;

    always_comb begin
        px_val = OUT_DW'(sat_s(64'(acc_nxt), OUT_DW));
`ifdef CONV_MC_RELU_EN
        // value is already in range, so its top bit is the true sign
        if (px_val[OUT_DW-1]) px_val = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_vld <= 1'b0;
            issue_c   <= '0;
            issue_r   <= '0;
            issue_q   <= '0;
            acc       <= '0;
        end else begin
            issue_vld <= (state == S_RUN);
            issue_c   <= c_cnt;
            issue_r   <= r_cnt;
            issue_q   <= q_cnt;
            if (issue_vld) acc <= acc_nxt;
        end
    end

    // Result map is deliberately left out of reset; it holds the last run.
    always_ff @(posedge clk) begin
        if (issue_vld && issue_c == C_LAST) out_buff[issue_r][issue_q] <= px_val;
    end

endmodule

// File: tb/tb_conv_mc_acc.sv
// Bench for conv_mc_acc: two instances on a 2-channel 5x5 image with a 3x3
// kernel, stride 1 (A, 3x3 output) and stride 2 (B, 2x2 output).
module tb_conv_mc_acc;
    localparam int IH = 5, IW = 5, KH = 3, KW = 3, CH = 2;
    localparam int DW = 24, WW = 8, AW = 40, ODW = 24;
    localparam int NA = 3 * 3 * CH;
    localparam int NB = 2 * 2 * CH;
    localparam longint PMAX = 64'sd8388607;
    localparam longint PMIN = -64'sd8388608;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic trig_a = 1'b0, trig_b = 1'b0;
    logic [CH-1:0][IH-1:0][IW-1:0][DW-1:0] in_img;
    logic [CH-1:0][KH-1:0][KW-1:0][WW-1:0] w_conv;
    logic signed [AW-1:0] bias;
    logic [3:0] cal_chan = 4'd0;
    logic busy_a, busy_b, ov_a, ov_b;
    logic [3:0] oc_a, oc_b;
    logic [2:0][2:0][ODW-1:0] ob_a;
    logic [1:0][1:0][ODW-1:0] ob_b;

    int img_m[CH][IH][IW];
    int w_m[CH][KH][KW];
    longint bias_m;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_mc_acc #(.K_H(KH), .K_W(KW), .IN_H(IH), .IN_W(IW), .STRIDE(1), .IN_CH(CH),
                  .DATA_W(DW), .W_W(WW), .ACC_W(AW), .OUT_DW(ODW)) dut_a (
        .clk(clk), .rst_n(rst_n), .trigger(trig_a), .in_img(in_img), .w_conv(w_conv),
        .bias(bias), .cal_chan(cal_chan), .busy(busy_a), .out_buff(ob_a),
        .out_valid(ov_a), .out_chan(oc_a));

    conv_mc_acc #(.K_H(KH), .K_W(KW), .IN_H(IH), .IN_W(IW), .STRIDE(2), .IN_CH(CH),
                  .DATA_W(DW), .W_W(WW), .ACC_W(AW), .OUT_DW(ODW)) dut_b (
        .clk(clk), .rst_n(rst_n), .trigger(trig_b), .in_img(in_img), .w_conv(w_conv),
        .bias(bias), .cal_chan(cal_chan), .busy(busy_b), .out_buff(ob_b),
        .out_valid(ov_b), .out_chan(oc_b));

    typedef struct {
        int     pv;
        int     wv;
        longint bv;
        bit     sel;
        longint exp;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint relu_f(input longint x);
`ifdef CONV_MC_RELU_EN
        return (x < 0) ? 64'sd0 : x;
`else
        return x;
`endif
    endfunction

    // Reference: direct strided correlation with 64-bit arithmetic, then clip.
    function automatic longint model_px(input int s, input int r, input int q);
        longint acc;
        acc = bias_m;
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < KH; i++)
                for (int j = 0; j < KW; j++)
                    acc += longint'(img_m[c][r*s+i][q*s+j]) * longint'(w_m[c][i][j]);
        if (acc > PMAX) acc = PMAX;
        if (acc < PMIN) acc = PMIN;
        return relu_f(acc);
    endfunction

    function automatic longint dut_px(input bit sel, input int r, input int q);
        logic signed [ODW-1:0] v;
        if (sel) v = ob_b[r][q];
        else     v = ob_a[r][q];
        return longint'(v);
    endfunction

    task automatic pack_inputs();
        for (int c = 0; c < CH; c++) begin
            for (int h = 0; h < IH; h++)
                for (int w = 0; w < IW; w++)
                    in_img[c][h][w] = DW'(img_m[c][h][w]);
            for (int i = 0; i < KH; i++)
                for (int j = 0; j < KW; j++)
                    w_conv[c][i][j] = WW'(w_m[c][i][j]);
        end
        bias = AW'(bias_m);
    endtask

    task automatic fill_uni(input int pv, input int wv, input longint bv);
        for (int c = 0; c < CH; c++) begin
            for (int h = 0; h < IH; h++)
                for (int w = 0; w < IW; w++) img_m[c][h][w] = pv;
            for (int i = 0; i < KH; i++)
                for (int j = 0; j < KW; j++) w_m[c][i][j] = wv;
        end
        bias_m = bv;
        pack_inputs();
    endtask

    task automatic fill_rand(input bit full);
        logic signed [DW-1:0] tp;
        logic signed [WW-1:0] tw;
        for (int c = 0; c < CH; c++) begin
            for (int h = 0; h < IH; h++)
                for (int w = 0; w < IW; w++) begin
                    tp = DW'($urandom);
                    img_m[c][h][w] = full ? int'(tp) : int'($urandom_range(0, 200)) - 100;
                end
            for (int i = 0; i < KH; i++)
                for (int j = 0; j < KW; j++) begin
                    tw = WW'($urandom);
                    w_m[c][i][j] = int'(tw);
                end
        end
        bias_m = longint'($urandom_range(0, 2000000)) - 64'sd1000000;
        pack_inputs();
    endtask

    // Starts a run, changes cal_chan mid-run, returns edges from the sampling
    // edge to the edge that sees out_valid (-1 on timeout).
    task automatic run(input bit sel, input logic [3:0] ch, output int lat);
        lat = -1;
        @(negedge clk);
        cal_chan = ch;
        if (sel) trig_b = 1'b1; else trig_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trig_a = 1'b0;
        trig_b = 1'b0;
        cal_chan = ~ch;
        check("busy_in_run", longint'(sel ? busy_b : busy_a), 1);
        for (int m = 0; m < 100; m++) begin
            if (sel ? ov_b : ov_a) begin
                lat = m + 1;
                break;
            end
            @(negedge clk);
        end
        check("out_chan", longint'(sel ? oc_b : oc_a), longint'(ch));
        @(negedge clk);
        check("valid_one_cycle", longint'(sel ? ov_b : ov_a), 0);
        @(negedge clk);
        check("idle_after_run", longint'(sel ? busy_b : busy_a), 0);
    endtask

    task automatic check_map(input bit sel, input string tag);
        int od;
        od = sel ? 2 : 3;
        for (int r = 0; r < od; r++)
            for (int q = 0; q < od; q++)
                check(tag, dut_px(sel, r, q), model_px(sel ? 2 : 1, r, q));
    endtask

    initial begin
        vec_t vt[9];
        int lat;
        int pulses[$];

        vt[0] = '{1, 1, 0, 1'b0, 18};
        vt[1] = '{1, 1, -20, 1'b1, -2};
        vt[2] = '{8388607, 127, 0, 1'b0, PMAX};
        vt[3] = '{-8388608, 127, 0, 1'b0, PMIN};
        vt[4] = '{-8388608, 127, 0, 1'b1, PMIN};
        vt[5] = '{3, -2, 5, 1'b0, -103};
        vt[6] = '{0, 0, -64'sd1073741824, 1'b1, PMIN};
        vt[7] = '{0, 5, 1000, 1'b0, 1000};
        vt[8] = '{100, -1, 1800, 1'b1, 0};

        fill_uni(0, 0, 0);
        #12;
        check("rst_busy_a", longint'(busy_a), 0);
        check("rst_valid_a", longint'(ov_a), 0);
        check("rst_chan_a", longint'(oc_a), 0);
        check("rst_busy_b", longint'(busy_b), 0);
        check("rst_valid_b", longint'(ov_b), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // uniform-pattern vectors with hand-computed expectations
        for (int v = 0; v < 9; v++) begin
            fill_uni(vt[v].pv, vt[v].wv, vt[v].bv);
            run(vt[v].sel, 4'(v + 3), lat);
            check("vec_latency", lat, vt[v].sel ? NB + 2 : NA + 2);
            for (int r = 0; r < (vt[v].sel ? 2 : 3); r++)
                for (int q = 0; q < (vt[v].sel ? 2 : 3); q++)
                    check("vec_px", dut_px(vt[v].sel, r, q), relu_f(vt[v].exp));
        end

        // random images against the reference model
        for (int t = 0; t < 8; t++) begin
            fill_rand(t >= 4);
            run(t[0], 4'($urandom_range(0, 15)), lat);
            check("rand_latency", lat, t[0] ? NB + 2 : NA + 2);
            check_map(t[0], "rand_px");
        end

        // trigger held high across two runs on A
        fill_rand(1'b0);
        @(negedge clk);
        cal_chan = 4'd9;
        trig_a = 1'b1;
        @(posedge clk);
        for (int m = 0; m <= 2 * NA + 5; m++) begin
            @(negedge clk);
            if (ov_a) pulses.push_back(m + 1);
        end
        trig_a = 1'b0;
        check("held_pulse_count", pulses.size(), 2);
        if (pulses.size() == 2) begin
            check("held_first", pulses[0], NA + 2);
            check("held_second", pulses[1], 2 * NA + 5);
        end
        repeat (3) @(negedge clk);
        check("held_idle", longint'(busy_a), 0);
        check_map(1'b0, "held_px");

        // reset at issue cycle 7, then a clean run
        fill_rand(1'b1);
        @(negedge clk);
        trig_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trig_a = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", longint'(busy_a), 0);
        check("midrst_valid", longint'(ov_a), 0);
        check("midrst_chan", longint'(oc_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_rand(1'b0);
        run(1'b0, 4'd12, lat);
        check("post_rst_latency", lat, NA + 2);
        check_map(1'b0, "post_rst_px");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
